// File: rtl/mem_arbiter_rr_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr_pkg
//
// Shared types and constants for the N-channel cacheline memory arbiter.
//   llc_cacheline  : one last-level-cache line (256 bits)
//   arb_state_t    : arbiter control states (IDLE, BUSY, DONE)
//   ARB_MODE_RR    : round-robin selection
//   ARB_MODE_FIXED : fixed priority, channel 0 highest
//   idx_width()    : width of a channel index, never less than one bit
// -----------------------------------------------------------------------------
package mem_arbiter_rr_pkg;

  localparam int LLC_LINE_W = 256;

  typedef logic [LLC_LINE_W-1:0] llc_cacheline;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam int ARB_MODE_RR    = 0;
  localparam int ARB_MODE_FIXED = 1;

  // A single channel still needs a 1-bit index so the grant port never
  // collapses to zero width.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
//
// Purely combinational winner selection for the memory arbiter.
//   MODE = ARB_MODE_RR    : first set request searching upward from ptr,
//                           wrapping from NUM_CH-1 back to 0.
//   MODE = ARB_MODE_FIXED : lowest set request index; ptr is ignored.
//
// Ports
//   req    in  NUM_CH  request vector, one bit per channel
//   ptr    in  IDX_W   round-robin starting index (must be < NUM_CH)
//   winner out IDX_W   selected channel (0 when nothing is requested)
//   valid  out 1       at least one request present
// -----------------------------------------------------------------------------
module rr_priority_picker
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int MODE   = ARB_MODE_RR,
  localparam int IDX_W = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  winner,
  output logic              valid
);

  assign valid = |req;

  // Both searches walk from the lowest priority candidate to the highest so
  // that the final assignment in the loop is the true winner.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    if (MODE == ARB_MODE_FIXED) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (req[IDX_W'(k)]) begin
          winner = IDX_W'(k);
        end
      end
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        // ptr is always below NUM_CH, so one conditional subtract wraps.
        idx = int'(ptr) + k;
        if (idx >= NUM_CH) begin
          idx = idx - NUM_CH;
        end
        if (req[IDX_W'(idx)]) begin
          winner = IDX_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr
//
// Arbitrates NUM_CH per-channel L2 caches onto a single cacheline adaptor.
// One read or write line transaction is outstanding at a time; the grant is
// held until pmem_resp, followed by one quiet DONE cycle so the finished
// requester can drop its request before the next arbitration.
//
// Parameters
//   NUM_CH  number of channels (2..8)
//   LINE_W  cacheline width
//   ADDR_W  address width
//   MODE    ARB_MODE_RR (round-robin) or ARB_MODE_FIXED (channel 0 highest)
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   ch_read       in   NUM_CH         per-channel line read request
//   ch_write      in   NUM_CH         per-channel line write request
//   ch_address    in   NUM_CH*ADDR_W  channel i at [i*ADDR_W +: ADDR_W]
//   ch_wdata      in   NUM_CH*LINE_W  channel i at [i*LINE_W +: LINE_W]
//   ch_rdata      out  LINE_W         read line, broadcast to every channel
//   ch_resp       out  NUM_CH         one-hot completion to granted channel
//   pmem_read     out  read request to the adaptor
//   pmem_write    out  write request to the adaptor
//   pmem_address  out  granted channel's address
//   pmem_wdata    out  granted channel's write line
//   pmem_rdata    in   line returned by the adaptor
//   pmem_resp     in   adaptor completion
//   arb_grant     out  current / last granted channel
//   arb_busy      out  high while a transaction is outstanding
// -----------------------------------------------------------------------------
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32,
  parameter int MODE   = ARB_MODE_RR,
  localparam int IDX_W = idx_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [ADDR_W-1:0]        pmem_address,
  output logic [LINE_W-1:0]        pmem_wdata,
  input  logic [LINE_W-1:0]        pmem_rdata,
  input  logic                     pmem_resp,
  output logic [IDX_W-1:0]         arb_grant,
  output logic                     arb_busy
);

  arb_state_t         state_reg,  state_next;
  logic [IDX_W-1:0]   grant_reg,  grant_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;

  logic [NUM_CH-1:0]  req;
  logic [IDX_W-1:0]   pick_winner;
  logic               pick_valid;

  logic [ADDR_W-1:0]  addr_arr  [NUM_CH];
  logic [LINE_W-1:0]  wdata_arr [NUM_CH];

  // ---------------------------------------------------------------------------
  // Unpack the flat per-channel buses so the grant can index them directly.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign addr_arr[gi]  = ch_address[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = ch_wdata[gi*LINE_W +: LINE_W];
  end

  assign req = ch_read | ch_write;

  rr_priority_picker #(
    .NUM_CH (NUM_CH),
    .MODE   (MODE)
  ) u_picker (
    .req    (req),
    .ptr    (rr_ptr_reg),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and request/response outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    ch_resp     = '0;

    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next = pick_winner;
          state_next = BUSY;
        end
      end

      BUSY: begin
        // A channel raising both strobes is treated as a write.
        pmem_write = ch_write[grant_reg];
        pmem_read  = ch_read[grant_reg] & ~ch_write[grant_reg];
        if (pmem_resp) begin
          ch_resp[grant_reg] = 1'b1;
          rr_ptr_next = (grant_reg == IDX_W'(NUM_CH - 1)) ? '0
                                                          : grant_reg + 1'b1;
          state_next  = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address and write data follow the grant at all times; the granted
  // requester holds them stable until its response.
  assign pmem_address = addr_arr[grant_reg];
  assign pmem_wdata   = wdata_arr[grant_reg];
  assign ch_rdata     = pmem_rdata;
  assign arb_grant    = grant_reg;
  assign arb_busy     = (state_reg == BUSY);

  // A granted channel may not withdraw its request before the adaptor
  // answers; the arbiter simply stays in BUSY if it does.
  always_ff @(posedge clk) begin
    if (!rst && state_reg == BUSY && !pmem_resp) begin
      assert (req[grant_reg])
        else $error("mem_arbiter_rr: channel %0d dropped its request while granted",
                    grant_reg);
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
module tb_mem_arbiter_rr;

  localparam int N  = 4;
  localparam int LW = 256;
  localparam int AW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_rr, rst_fx;
  logic [N-1:0]    ch_read, ch_write;
  logic [N*AW-1:0] ch_address;
  logic [N*LW-1:0] ch_wdata;
  logic [LW-1:0]   pmem_rdata;
  logic            pmem_resp;

  logic [LW-1:0] rdata_rr, rdata_fx, wdata_rr, wdata_fx;
  logic [N-1:0]  resp_rr, resp_fx;
  logic          rd_rr, rd_fx, wr_rr, wr_fx, busy_rr, busy_fx;
  logic [AW-1:0] addr_rr, addr_fx;
  logic [IW-1:0] grant_rr, grant_fx;

  mem_arbiter_rr #(.NUM_CH(N), .LINE_W(LW), .ADDR_W(AW), .MODE(0)) dut_rr (
    .clk(clk), .rst(rst_rr), .ch_read(ch_read), .ch_write(ch_write),
    .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_rdata(rdata_rr),
    .ch_resp(resp_rr), .pmem_read(rd_rr), .pmem_write(wr_rr),
    .pmem_address(addr_rr), .pmem_wdata(wdata_rr), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .arb_grant(grant_rr), .arb_busy(busy_rr));

  mem_arbiter_rr #(.NUM_CH(N), .LINE_W(LW), .ADDR_W(AW), .MODE(1)) dut_fx (
    .clk(clk), .rst(rst_fx), .ch_read(ch_read), .ch_write(ch_write),
    .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_rdata(rdata_fx),
    .ch_resp(resp_fx), .pmem_read(rd_fx), .pmem_write(wr_fx),
    .pmem_address(addr_fx), .pmem_wdata(wdata_fx), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .arb_grant(grant_fx), .arb_busy(busy_fx));

  // The instance not under test is held in reset; o_* view the active one.
  bit            use_fx;
  logic [LW-1:0] o_rdata, o_wdata;
  logic [N-1:0]  o_resp;
  logic          o_read, o_write, o_busy;
  logic [AW-1:0] o_addr;
  logic [IW-1:0] o_grant;

  always_comb begin
    o_rdata = use_fx ? rdata_fx : rdata_rr;
    o_wdata = use_fx ? wdata_fx : wdata_rr;
    o_resp  = use_fx ? resp_fx  : resp_rr;
    o_read  = use_fx ? rd_fx    : rd_rr;
    o_write = use_fx ? wr_fx    : wr_rr;
    o_busy  = use_fx ? busy_fx  : busy_rr;
    o_addr  = use_fx ? addr_fx  : addr_rr;
    o_grant = use_fx ? grant_fx : grant_rr;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ptr  = 0;

  // Reference arbitration: scan channels in priority order.
  function automatic int model_pick(input logic [N-1:0] r, input int ptr, input bit fixed);
    for (int k = 0; k < N; k++) begin
      automatic int c = fixed ? k : (ptr + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic randomize_channels();
    for (int i = 0; i < N; i++) begin
      ch_address[i*AW +: AW] = $urandom;
      ch_wdata[i*LW +: LW]   = rand_line();
    end
  endtask

  // Leaves the selected instance in IDLE at the start of a drive cycle.
  task automatic do_reset(input bit fx);
    use_fx    = fx;
    rst_rr    = 1'b1;
    rst_fx    = 1'b1;
    ch_read   = '0;
    ch_write  = '0;
    pmem_resp = 1'b0;
    next_cycle();
    next_cycle();
    if (fx) rst_fx = 1'b0;
    else    rst_rr = 1'b0;
    exp_ptr = 0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    use_fx = 0;
    rst_rr = 1'b1;
    rst_fx = 1'b1;
    randomize_channels();
    ch_read    = '1;
    ch_write   = '0;
    pmem_resp  = 1'b1;
    pmem_rdata = rand_line();
    next_cycle();
    next_cycle();
    settle();
    n_checks++;
    if ({rd_rr, wr_rr, busy_rr, rd_fx, wr_fx, busy_fx} !== 6'b0)
      $display("FAIL reset_strobes: got %b want 000000", {rd_rr, wr_rr, busy_rr, rd_fx, wr_fx, busy_fx});
    else n_pass++;
    n_checks++;
    if ({resp_rr, resp_fx} !== 8'b0)
      $display("FAIL reset_resp: got %b want 00000000", {resp_rr, resp_fx});
    else n_pass++;
    n_checks++;
    if (o_grant !== 2'd0) $display("FAIL reset_grant: got %0d want 0", o_grant);
    else n_pass++;
    n_checks++;
    if (o_addr !== ch_address[0 +: AW])
      $display("FAIL reset_addr: got %h want %h", o_addr, ch_address[0 +: AW]);
    else n_pass++;
    n_checks++;
    if (o_wdata !== ch_wdata[0 +: LW])
      $display("FAIL reset_wdata: got %h want %h", o_wdata, ch_wdata[0 +: LW]);
    else n_pass++;
    n_checks++;
    if (o_rdata !== pmem_rdata) $display("FAIL reset_rdata: got %h want %h", o_rdata, pmem_rdata);
    else n_pass++;
    $display("reset: strobes/resp/grant/addr checked");
    pmem_resp = 1'b0;
    ch_read   = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_read();
    logic [LW-1:0] line;
    do_reset(0);
    randomize_channels();
    ch_address[1*AW +: AW] = 32'h0000_1040;
    ch_read = 4'b0010;
    settle();
    n_checks++;
    if (o_read !== 1'b0) $display("FAIL single_idle_read: got %b want 0", o_read);
    else n_pass++;
    next_cycle();
    settle();
    n_checks++;
    if ({o_read, o_write, o_busy, o_grant} !== {3'b101, 2'd1})
      $display("FAIL single_grant: got rd=%b wr=%b busy=%b g=%0d want 1 0 1 1", o_read, o_write, o_busy, o_grant);
    else n_pass++;
    n_checks++;
    if (o_addr !== 32'h0000_1040) $display("FAIL single_addr: got %h want 00001040", o_addr);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      settle();
      n_checks++;
      if ({o_read, o_resp} !== {1'b1, 4'b0000})
        $display("FAIL single_wait[%0d]: got rd=%b resp=%b want 1 0000", c, o_read, o_resp);
      else n_pass++;
    end
    next_cycle();
    line = {32{8'hA5}};
    pmem_rdata = line;
    pmem_resp  = 1'b1;
    settle();
    n_checks++;
    if (o_resp !== 4'b0010) $display("FAIL single_resp: got %b want 0010", o_resp);
    else n_pass++;
    n_checks++;
    if (o_rdata !== line) $display("FAIL single_rdata: got %h want %h", o_rdata, line);
    else n_pass++;
    next_cycle();
    pmem_resp = 1'b0;
    ch_read   = '0;
    settle();
    n_checks++;
    if ({o_read, o_write, o_busy, o_resp} !== 7'b0)
      $display("FAIL single_done: got %b want 0000000", {o_read, o_write, o_busy, o_resp});
    else n_pass++;
    next_cycle();
    $display("single_read: ch1 addr 00001040 completed");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_rr_fairness();
    int order[5] = '{0, 1, 2, 3, 0};
    int g;
    do_reset(0);
    randomize_channels();
    ch_read = '1;
    for (int t = 0; t < 5; t++) begin
      g = model_pick(ch_read | ch_write, exp_ptr, 0);
      next_cycle();
      settle();
      n_checks++;
      if ({o_read, o_grant} !== {1'b1, IW'(order[t])})
        $display("FAIL rr_grant[%0d]: got rd=%b g=%0d want 1 %0d", t, o_read, o_grant, order[t]);
      else n_pass++;
      n_checks++;
      if (o_addr !== ch_address[g*AW +: AW])
        $display("FAIL rr_addr[%0d]: got %h want %h", t, o_addr, ch_address[g*AW +: AW]);
      else n_pass++;
      repeat ($urandom_range(0, 3)) next_cycle();
      next_cycle();
      pmem_resp = 1'b1;
      settle();
      n_checks++;
      if (o_resp !== (4'b0001 << g)) $display("FAIL rr_resp[%0d]: got %b want %b", t, o_resp, 4'b0001 << g);
      else n_pass++;
      exp_ptr = (g + 1) % N;
      $display("rr_fairness: txn %0d granted ch%0d", t, g);
      next_cycle();
      pmem_resp  = 1'b0;
      ch_read[g] = 1'b0;
      next_cycle();
      ch_read[g] = 1'b1;
    end
    ch_read = '0;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fixed_priority();
    int g;
    do_reset(1);
    randomize_channels();
    ch_read = 4'b0101;
    for (int t = 0; t < 4; t++) begin
      g = model_pick(ch_read | ch_write, exp_ptr, 1);
      next_cycle();
      settle();
      n_checks++;
      if ({o_read, o_grant} !== {1'b1, IW'(g)})
        $display("FAIL fixed_grant[%0d]: got rd=%b g=%0d want 1 %0d", t, o_read, o_grant, g);
      else n_pass++;
      repeat ($urandom_range(0, 2)) next_cycle();
      next_cycle();
      pmem_resp = 1'b1;
      settle();
      n_checks++;
      if (o_resp !== (4'b0001 << g)) $display("FAIL fixed_resp[%0d]: got %b want %b", t, o_resp, 4'b0001 << g);
      else n_pass++;
      $display("fixed_priority: txn %0d granted ch%0d", t, g);
      next_cycle();
      pmem_resp  = 1'b0;
      ch_read[g] = 1'b0;
      next_cycle();
      // ch0 keeps coming back for three transactions, then stops for good.
      if (t < 2) ch_read[g] = 1'b1;
    end
    ch_read = '0;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_write_precedence();
    logic [LW-1:0] line;
    do_reset(0);
    randomize_channels();
    line = {16{16'hDEAD}};
    ch_wdata[0 +: LW] = line;
    ch_read  = 4'b0001;
    ch_write = 4'b0001;
    next_cycle();
    settle();
    n_checks++;
    if ({o_write, o_read} !== 2'b10) $display("FAIL wprec_strobes: got wr=%b rd=%b want 1 0", o_write, o_read);
    else n_pass++;
    n_checks++;
    if (o_wdata !== line) $display("FAIL wprec_wdata: got %h want %h", o_wdata, line);
    else n_pass++;
    next_cycle();
    pmem_resp = 1'b1;
    settle();
    n_checks++;
    if (o_resp !== 4'b0001) $display("FAIL wprec_resp: got %b want 0001", o_resp);
    else n_pass++;
    $display("write_precedence: ch0 read+write issued as write");
    next_cycle();
    pmem_resp = 1'b0;
    ch_read   = '0;
    ch_write  = '0;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_busy();
    int g;
    do_reset(0);
    randomize_channels();
    // Complete one transaction on ch2 so the pointer moves away from 0.
    ch_read = 4'b0100;
    next_cycle();
    next_cycle();
    pmem_resp = 1'b1;
    next_cycle();
    pmem_resp = 1'b0;
    ch_read   = '0;
    exp_ptr   = 3;
    next_cycle();
    ch_read = 4'b1010;
    g = model_pick(ch_read, exp_ptr, 0);
    next_cycle();
    settle();
    n_checks++;
    if (o_grant !== IW'(g)) $display("FAIL rstbusy_grant: got %0d want %0d", o_grant, g);
    else n_pass++;
    next_cycle();
    next_cycle();
    rst_rr = 1'b1;
    next_cycle();
    rst_rr    = 1'b0;
    pmem_resp = 1'b1;
    exp_ptr   = 0;
    settle();
    n_checks++;
    if ({o_read, o_write, o_busy, o_resp, o_grant} !== 9'b0)
      $display("FAIL rstbusy_outputs: got %b want 000000000", {o_read, o_write, o_busy, o_resp, o_grant});
    else n_pass++;
    g = model_pick(ch_read, exp_ptr, 0);
    next_cycle();
    pmem_resp = 1'b0;
    settle();
    n_checks++;
    if ({o_read, o_grant} !== {1'b1, IW'(g)})
      $display("FAIL rstbusy_regrant: got rd=%b g=%0d want 1 %0d", o_read, o_grant, g);
    else n_pass++;
    $display("reset_busy: abandoned ch3, re-granted ch%0d", g);
    next_cycle();
    pmem_resp = 1'b1;
    next_cycle();
    pmem_resp = 1'b0;
    ch_read   = '0;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [AW-1:0] a2;
    do_reset(0);
    randomize_channels();
    ch_read = 4'b0010;
    next_cycle();
    next_cycle();
    pmem_resp = 1'b1;
    settle();
    n_checks++;
    if (o_resp !== 4'b0010) $display("FAIL b2b_resp: got %b want 0010", o_resp);
    else n_pass++;
    next_cycle();
    pmem_resp = 1'b0;
    a2 = $urandom;
    ch_address[1*AW +: AW] = a2;
    settle();
    n_checks++;
    if ({o_read, o_resp} !== 5'b0) $display("FAIL b2b_r1: got rd=%b resp=%b want 0 0000", o_read, o_resp);
    else n_pass++;
    next_cycle();
    settle();
    n_checks++;
    if (o_read !== 1'b0) $display("FAIL b2b_r2: got %b want 0", o_read);
    else n_pass++;
    next_cycle();
    settle();
    n_checks++;
    if ({o_read, o_addr} !== {1'b1, a2}) $display("FAIL b2b_r3: got rd=%b addr=%h want 1 %h", o_read, o_addr, a2);
    else n_pass++;
    $display("back_to_back: next request at r+3");
    next_cycle();
    pmem_resp = 1'b1;
    next_cycle();
    pmem_resp = 1'b0;
    ch_read   = '0;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random(input bit fx);
    logic [N-1:0]  mask;
    logic [7:0]    rw;
    logic [LW-1:0] line;
    int g;
    do_reset(fx);
    for (int t = 0; t < 12; t++) begin
      randomize_channels();
      mask = 4'($urandom_range(1, 15));
      rw   = 8'($urandom);
      ch_write = mask & rw[3:0];
      ch_read  = mask & (rw[7:4] | ~rw[3:0]);
      g = model_pick(mask, exp_ptr, fx);
      next_cycle();
      settle();
      n_checks++;
      if ({o_grant, o_write, o_read} !== {IW'(g), ch_write[g], ch_read[g] & ~ch_write[g]})
        $display("FAIL rand%0d_grant[%0d]: got g=%0d wr=%b rd=%b want %0d %b %b", fx, t, o_grant, o_write, o_read,
                 g, ch_write[g], ch_read[g] & ~ch_write[g]);
      else n_pass++;
      n_checks++;
      if ({o_addr, o_wdata} !== {ch_address[g*AW +: AW], ch_wdata[g*LW +: LW]})
        $display("FAIL rand%0d_data[%0d]: got addr=%h want %h", fx, t, o_addr, ch_address[g*AW +: AW]);
      else n_pass++;
      repeat ($urandom_range(0, 3)) next_cycle();
      next_cycle();
      line = rand_line();
      pmem_rdata = line;
      pmem_resp  = 1'b1;
      settle();
      n_checks++;
      if ({o_resp, o_rdata} !== {4'b0001 << g, line})
        $display("FAIL rand%0d_resp[%0d]: got %b want %b", fx, t, o_resp, 4'b0001 << g);
      else n_pass++;
      exp_ptr = (g + 1) % N;
      $display("random mode=%0d: txn %0d mask=%b granted ch%0d", fx, t, mask, g);
      next_cycle();
      pmem_resp = 1'b0;
      ch_read   = '0;
      ch_write  = '0;
      next_cycle();
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    use_fx     = 0;
    rst_rr     = 1'b1;
    rst_fx     = 1'b1;
    ch_read    = '0;
    ch_write   = '0;
    ch_address = '0;
    ch_wdata   = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    #1;
    test_reset();
    test_single_read();
    test_rr_fairness();
    test_fixed_priority();
    test_write_precedence();
    test_reset_busy();
    test_back_to_back();
    test_random(0);
    test_random(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
